// File: rtl/snn_pkg.sv
// Shared types and width helpers for the spiking-network winner-take-all controller.
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } snn_state_e;

    // A single class or a budget of one still needs one bit of index.
    function automatic int cls_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cyc_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/snn_prio_enc.sv
// Lowest-index-first priority encoder over the neuron fire flags.
module snn_prio_enc
    import snn_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_req,
    output logic [cls_w(N)-1:0] o_index,
    output logic                o_any
);

    localparam int IW = cls_w(N);

    // Scan downward so the last hit written is the lowest set bit.
    always_comb begin
        o_index = '0;
        o_any   = |i_req;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_index = IW'(i);
        end
    end

endmodule

// File: rtl/snn_wta_ctrl.sv
// Winner-take-all controller: arms the neuron bank, streams spikes, and reports the first neuron to saturate.
module snn_wta_ctrl
    import snn_pkg::*;
#(
    parameter int N_CLASSES  = 10,
    parameter int MAX_CYCLES = 2048
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N_CLASSES-1:0]          fire_i,
    output logic                          neuron_rst_n,
    output logic                          spike_en,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [cls_w(N_CLASSES)-1:0]   result_class,
    output logic                          result_timeout,
    output logic [cyc_w(MAX_CYCLES)-1:0]  result_cycles
);

    localparam int CW = cls_w(N_CLASSES);
    localparam int TW = cyc_w(MAX_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(MAX_CYCLES - 1);

    snn_state_e    r_state, w_next;
    logic [TW-1:0] r_cnt;
    logic [CW-1:0] r_class;
    logic [TW-1:0] r_cycles;
    logic          r_timeout;
    logic [CW-1:0] w_idx;
    logic          w_any;

    snn_prio_enc #(.N(N_CLASSES)) u_prio (
        .i_req   (fire_i),
        .o_index (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ARM;
            S_ARM:   w_next = S_RUN;
            S_RUN:   if (w_any || (r_cnt == LAST)) w_next = S_DONE;
            S_DONE:  if (result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counter stops advancing once a decision is taken, so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_class   <= '0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_ARM: r_cnt <= '0;
                S_RUN: begin
                    if (w_any) begin
                        r_class   <= w_idx;
                        r_cycles  <= r_cnt;
                        r_timeout <= 1'b0;
                    end else if (r_cnt == LAST) begin
                        r_class   <= '0;
                        r_cycles  <= LAST;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Neuron reset stays released in DONE so balances remain readable.
    assign neuron_rst_n   = (r_state != S_IDLE);
    assign spike_en       = (r_state == S_RUN);
    assign busy           = (r_state != S_IDLE);
    assign result_valid   = (r_state == S_DONE);
    assign result_class   = r_class;
    assign result_cycles  = r_cycles;
    assign result_timeout = r_timeout;

endmodule

// File: tb/tb_snn_wta_ctrl.sv
// Directed and randomized classification runs checked against a first-fire reference model.
module tb_snn_wta_ctrl;

    localparam int N = 4;
    localparam int M = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       result_ready = 1'b0;
    logic [3:0] fire_i = '0;
    logic       neuron_rst_n, spike_en, busy, result_valid, result_timeout;
    logic [1:0] result_class;
    logic [3:0] result_cycles;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] fv [M];
    int         e_cls, e_cyc;
    logic       e_to;

    always #5 clk = ~clk;

    snn_wta_ctrl #(.N_CLASSES(N), .MAX_CYCLES(M)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .fire_i         (fire_i),
        .neuron_rst_n   (neuron_rst_n),
        .spike_en       (spike_en),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_class   (result_class),
        .result_timeout (result_timeout),
        .result_cycles  (result_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First RUN cycle with any fire decides; lowest set bit is isolated arithmetically.
    task automatic model();
        logic [3:0] iso;
        e_cls = 0;
        e_cyc = M - 1;
        e_to  = 1'b1;
        for (int k = 0; k < M; k++) begin
            if (fv[k] != 4'd0) begin
                iso   = fv[k] & (~fv[k] + 4'd1);
                e_cls = $clog2(iso);
                e_cyc = k;
                e_to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_fv();
        for (int k = 0; k < M; k++) fv[k] = 4'd0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_vld"}, 32'(result_valid), 32'd1);
        chk({tag, "_cls"}, 32'(result_class), 32'(e_cls));
        chk({tag, "_cyc"}, 32'(result_cycles), 32'(e_cyc));
        chk({tag, "_to"},  32'(result_timeout), 32'(e_to));
    endtask

    task automatic classify(input string tag, input int hold, input bit poke_start);
        model();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_arm_busy"}, 32'(busy), 32'd1);
        chk({tag, "_arm_spk"},  32'(spike_en), 32'd0);
        chk({tag, "_arm_nrst"}, 32'(neuron_rst_n), 32'd1);
        tick();
        for (int k = 0; k <= e_cyc; k++) begin
            chk({tag, "_run_spk"}, 32'(spike_en), 32'd1);
            chk({tag, "_run_vld"}, 32'(result_valid), 32'd0);
            fire_i = fv[k];
            tick();
        end
        fire_i = 4'd0;
        chk({tag, "_done_spk"},  32'(spike_en), 32'd0);
        chk({tag, "_done_nrst"}, 32'(neuron_rst_n), 32'd1);
        check_result({tag, "_done"});
        for (int h = 0; h < hold; h++) begin
            start = poke_start;
            tick();
            chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
            check_result({tag, "_hold"});
        end
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk({tag, "_idle_vld"},  32'(result_valid), 32'd0);
        chk({tag, "_idle_nrst"}, 32'(neuron_rst_n), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_spk"},  32'(spike_en), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_nrst", 32'(neuron_rst_n), 32'd0);
        chk("rst_spk",  32'(spike_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld",  32'(result_valid), 32'd0);
        chk("rst_cls",  32'(result_class), 32'd0);
        chk("rst_to",   32'(result_timeout), 32'd0);
        chk("rst_cyc",  32'(result_cycles), 32'd0);
        rst = 1'b1;
        tick();

        clear_fv(); fv[5] = 4'b0100;
        classify("fire_c5", 0, 1'b0);
        clear_fv(); fv[0] = 4'b1010;
        classify("fire_c0", 1, 1'b0);
        clear_fv();
        classify("timeout", 0, 1'b0);
        clear_fv(); fv[3] = 4'b0010;
        classify("hold10", 10, 1'b1);
        clear_fv(); fv[15] = 4'b0001;
        classify("fire_last", 0, 1'b0);

        // Reset in the middle of RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("mid_run_spk", 32'(spike_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_spk",  32'(spike_en), 32'd0);
        chk("arst_nrst", 32'(neuron_rst_n), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        fire_i = 4'b0001;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_vld",  32'(result_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        fire_i = 4'd0;

        // Start driven together with reset release is taken on the next edge.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rel_start_busy", 32'(busy), 32'd1);
        fire_i = 4'b1000;
        tick();
        tick();
        fire_i = 4'd0;
        chk("rel_vld", 32'(result_valid), 32'd1);
        chk("rel_cls", 32'(result_class), 32'd3);
        chk("rel_cyc", 32'(result_cycles), 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("rel_idle_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < M; k++)
                fv[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            classify("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_wta_ctrl.md
SNN_WTA_CTRL -- requirements
Module: snn_wta_ctrl

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10: number of output neurons arbitrated.
REQ-002 SHALL have parameter MAX_CYCLES, default 2048: RUN-cycle budget before timeout; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begin one classification; sampled in IDLE only.
REQ-006 SHALL have port fire_i, input, N_CLASSES: per-neuron saturation flags from the output neuron bank.
REQ-007 SHALL have port neuron_rst_n, output, 1: active-low reset to the neuron bank.
REQ-008 SHALL have port spike_en, output, 1: gates the pixel spike stream into the bank.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port result_valid, output, 1: result available.
REQ-011 SHALL have port result_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port result_class, output, clog2(N_CLASSES): winning neuron index.
REQ-013 SHALL have port result_timeout, output, 1: no neuron fired within budget.
REQ-014 SHALL have port result_cycles, output, clog2(MAX_CYCLES): RUN-cycle index at decision.

Function
REQ-015 SHALL implement states IDLE, ARM, RUN, DONE; all outputs Moore-decoded from registered state and result registers.
REQ-016 IDLE: neuron_rst_n=0, spike_en=0; start=1 -> ARM next cycle.
REQ-017 ARM (exactly 1 cycle): neuron_rst_n=1, spike_en=0, cycle counter cleared to 0 -> RUN.
REQ-018 RUN: neuron_rst_n=1, spike_en=1; counter increments by 1 each RUN cycle, first RUN cycle has count 0.
REQ-019 RUN, fire_i != 0: capture lowest set index into result_class, count into result_cycles, result_timeout=0 -> DONE.
REQ-020 RUN, fire_i == 0 and count == MAX_CYCLES-1: result_class=0, result_cycles=MAX_CYCLES-1, result_timeout=1 -> DONE.
REQ-021 Fire and timeout in the same cycle: fire wins, result_timeout=0.
REQ-022 DONE: neuron_rst_n=1 (neuron balances stay readable), spike_en=0, result_valid=1.
REQ-023 DONE: result fields SHALL stay constant while result_valid=1 and result_ready=0.
REQ-024 DONE with result_ready=1 -> IDLE next cycle; result_valid drops same edge.
REQ-025 start while busy=1 SHALL be ignored, not queued.
REQ-026 Counter SHALL never wrap; it holds at MAX_CYCLES-1 maximum.
REQ-027 Multiple simultaneous fire bits: lowest index wins deterministically.

Reset
REQ-028 rst low SHALL force, asynchronously: state=IDLE, neuron_rst_n=0, spike_en=0, busy=0, result_valid=0, result_class=0, result_timeout=0, result_cycles=0, counter=0.
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the result with no result_valid pulse.
REQ-030 After rst rises, first start SHALL be accepted on the next rising edge.

Structure
REQ-031 Shared package snn_pkg SHALL hold the state enum and width helper functions for class index and cycle count.
REQ-032 Lowest-index-first priority encoder SHALL be the sub-module snn_prio_enc (parameter N, outputs index and any).

Verification (N_CLASSES=4, MAX_CYCLES=16)
REQ-033 start; fire_i=4'b0100 in RUN count 5 -> result_class=2, result_cycles=5, result_timeout=0, spike_en low next cycle.
REQ-034 fire_i=4'b1010 at RUN count 0 -> result_class=1, result_cycles=0.
REQ-035 fire_i held 0 -> DONE after 16 RUN cycles, result_timeout=1, result_class=0, result_cycles=15.
REQ-036 result_ready low 10 cycles in DONE, start pulsed -> result fields stable, state stays DONE; ready=1 -> IDLE, neuron_rst_n=0.
REQ-037 rst low at RUN count 7 -> same instant spike_en=0, neuron_rst_n=0, busy=0; no result_valid after release.
REQ-038 fire at count 15 with fire_i=4'b0001 -> result_class=0, result_timeout=0.
